// File: rtl/v_bb_requester.sv
// Requester stage: issues one REQ per accepted command, tracks in-flight requests
// against credits, and buffers ACK data in a response FIFO. Optional watchdog: REQ_TIMEOUT_EN.
module v_bb_requester #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int TIMEOUT         = 16
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    output logic       REQ,
    input  logic       ACK,
    input  logic [2:0] DATA,
    output logic       RSP_VALID,
    input  logic       RSP_READY,
    output logic [2:0] RSP_DATA,
    output logic [2:0] OUTSTANDING,
    output logic       IDLE,
    output logic       ERR
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DRAIN  = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      out_q, out_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [2:0]      mem_q [FIFO_DEPTH];
    logic            req_q;
    logic            rdy_q, rdy_d;

    logic in_err_s, accept_s, ack_ok_s, spurious_s, push_s, pop_s, timeout_s;

    assign in_err_s   = (state_q == S_ERR);
    assign accept_s   = CMD_VALID & rdy_q;
    assign ack_ok_s   = ACK & ~in_err_s & (out_q != 3'd0);
    assign spurious_s = ACK & ~in_err_s & (out_q == 3'd0);
    assign push_s     = ack_ok_s;
    assign pop_s      = (cnt_q != CW'(1'b0)) & RSP_READY;

`ifdef REQ_TIMEOUT_EN
    logic [7:0] wd_q, wd_d;

    // Watchdog: counts cycles without a valid ACK while requests are in flight
    always_comb begin
        wd_d = wd_q;
        if (in_err_s || (out_q == 3'd0) || ack_ok_s) begin
            wd_d = 8'd0;
        end else if (wd_q != 8'(TIMEOUT)) begin
            wd_d = wd_q + 8'd1;
        end else begin
            wd_d = wd_q;
        end
    end

    // Watchdog register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wd_q <= 8'd0;
        end else begin
            wd_q <= wd_d;
        end
    end

    assign timeout_s = (wd_q == 8'(TIMEOUT)) & ~in_err_s;
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state: credit counter, FIFO pointers, FSM and registered ready
    always_comb begin
        out_d   = out_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        state_d = state_q;
        rdy_d   = 1'b0;

        case ({accept_s, ack_ok_s})
            2'b10:   out_d = out_q + 3'd1;
            2'b01:   out_d = out_q - 3'd1;
            default: out_d = out_q;
        endcase

        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CW'(1'b1);
            2'b01:   cnt_d = cnt_q - CW'(1'b1);
            default: cnt_d = cnt_q;
        endcase

        if (push_s) begin
            wr_d = wr_q + AW'(1'b1);
        end else begin
            wr_d = wr_q;
        end
        if (pop_s) begin
            rd_d = rd_q + AW'(1'b1);
        end else begin
            rd_d = rd_q;
        end

        // Non-error state is derived from the post-edge occupancy
        case (state_q)
            S_ERR: state_d = S_ERR;
            default: begin
                if (spurious_s || timeout_s) begin
                    state_d = S_ERR;
                end else if (out_d != 3'd0) begin
                    state_d = S_ACTIVE;
                end else if (cnt_d != CW'(1'b0)) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase

        rdy_d = (state_d != S_ERR) &&
                (out_d < 3'(MAX_OUTSTANDING)) &&
                ((8'(out_d) + 8'(cnt_d)) < 8'(FIFO_DEPTH));
    end

    // State, credit and FIFO registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            out_q   <= 3'd0;
            cnt_q   <= CW'(1'b0);
            wr_q    <= AW'(1'b0);
            rd_q    <= AW'(1'b0);
            req_q   <= 1'b0;
            rdy_q   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 3'd0;
            end
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            req_q   <= accept_s;
            rdy_q   <= rdy_d;
            if (push_s) begin
                mem_q[wr_q] <= DATA;
            end else begin
                mem_q[wr_q] <= mem_q[wr_q];
            end
        end
    end

    assign CMD_READY   = rdy_q;
    assign REQ         = req_q;
    assign RSP_VALID   = (cnt_q != CW'(1'b0));
    assign RSP_DATA    = mem_q[rd_q];
    assign OUTSTANDING = out_q;
    assign IDLE        = (state_q == S_IDLE);
    assign ERR         = (state_q == S_ERR);
endmodule
